and_gadget_arbiter: RTL and testbench
=====================================

Name: and_gadget_arbiter

Overview:
- Shares one masked AND gadget (D-bit ina/inb/rin, AndEnable/AndDone handshake, out) among N requesters.
- Round-robin arbitration; latches the winner's operands and supplies fresh mask bits from an internal 16-bit LFSR.
- Sequences the gadget's enable/done handshake and returns the result to the winner with a one-cycle ack.
- Sits between requester datapaths and a single AND instance to save area.

Parameters:
- N, 2, number of requesters (2..8)
- D, 3, operand/result width (1..16)
- SEED, 16'hACE1, LFSR reset value (nonzero)
- TIMEOUT, 16, watchdog limit in cycles (used only with AND_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N  per-requester request level
- ina_bus  in  N*D  operand A; requester i uses slice [i*D +: D]
- inb_bus  in  N*D  operand B; same slicing
- ack  out  N  one-cycle done pulse to the served requester
- res  out  D  result, valid only while any ack bit is high
- timeout  out  1  one-cycle pulse with ack on watchdog abort
- busy  out  1  high in any state other than IDLE
- and_ina  out  D  to gadget ina
- and_inb  out  D  to gadget inb
- and_rin  out  D  to gadget rin
- AndEnable  out  1  to gadget enable
- AndDone  in  1  from gadget done
- and_out  in  D  from gadget out

Behaviour:
- Reset (rst=1 at clk edge):
  - Outputs: ack=0, res=0, timeout=0, busy=0, AndEnable=0, and_ina/and_inb/and_rin=0.
  - State: state=IDLE, rr_ptr=0, lfsr=SEED.
  - Reset mid-operation aborts immediately: no ack; AndEnable is low the next cycle.
- FSM states: IDLE, RUN, RESP, DRAIN.
- IDLE:
  - If req != 0, grant the first set bit searching from rr_ptr upward, wrapping modulo N.
  - Latch and_ina/and_inb from the winner's slices and and_rin = lfsr[D-1:0].
  - Advance lfsr once (Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0).
  - Store the winner index g; go to RUN.
- RUN:
  - AndEnable=1 for the whole state; operands held stable.
  - On a cycle where AndDone=1: capture res=and_out, go to RESP. AndEnable is 0 from the next cycle.
- RESP (exactly 1 cycle):
  - ack[g]=1, res valid; rr_ptr=(g+1) mod N.
  - Go to DRAIN if AndDone=1, else go to IDLE.
- DRAIN:
  - AndEnable=0; wait until AndDone=0, then go to IDLE. No new grant until then.
- Latency: grant at req+1 cycle; AndEnable high at req+1. ack appears the cycle after AndDone is sampled high.
- Requester rules:
  - Operands are latched at grant; changes after grant are ignored.
  - req may stay high after ack; the requester is then re-arbitrated fairly.
  - req dropped before grant is simply not served.
  - Bits of req for the requester in service are ignored until its ack.
- Simultaneous requests: resolved strictly by round-robin from rr_ptr. No requester waits more than N-1 grants.
- AndDone high while in IDLE: ignored.
- The LFSR advances only on grant; it never reaches zero because SEED is nonzero.

Optional Feature:
- Macro: AND_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT with AndDone still 0: go to RESP with res=0 and timeout=1 together with ack[g]=1, then go to DRAIN.
  - If AndDone and expiry coincide, AndDone wins: normal result, timeout=0.
- Not defined: no counter; RUN waits indefinitely; timeout tied to 0.

Test Plan:
- Bench gadget model: out = (ina & inb) ^ rin, AndDone high 3 cycles after AndEnable rises, held until AndEnable falls.
- Reset, N=2, D=3, req=01, A0=111, B0=110 -> and_rin=001 (SEED low bits); ack=01 with res=111; busy low after DRAIN; AndEnable high for exactly 4 cycles.
- req=11 held, A0=000, B0=110, A1=011, B1=011 -> grants alternate 0,1,0,1; each ack is one cycle; and_rin differs between consecutive grants (LFSR sequence from ACE1).
- Assert rst during RUN -> AndEnable=0 and ack=0 next cycle; next grant uses and_rin=001 again.
- Gadget holds AndDone high 5 extra cycles after ack -> arbiter stays in DRAIN; no new AndEnable until AndDone=0, even with req=10 pending.
- With AND_TIMEOUT_EN, TIMEOUT=16, gadget never asserts AndDone -> after 16 RUN cycles: ack[g]=1, timeout=1, res=000; arbiter then serves the next requester normally.

Source files
------------

// File: rtl/and_gadget_arbiter.sv
// Round-robin arbiter sharing one masked AND gadget among N requesters, with LFSR mask bits.
// Define AND_TIMEOUT_EN to compile in a watchdog that aborts a gadget that never signals done.
module and_gadget_arbiter #(
    parameter int          N       = 2,
    parameter int          D       = 3,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*D-1:0] ina_bus,
    input  logic [N*D-1:0] inb_bus,
    output logic [N-1:0]   ack,
    output logic [D-1:0]   res,
    output logic           timeout,
    output logic           busy,
    output logic [D-1:0]   and_ina,
    output logic [D-1:0]   and_inb,
    output logic [D-1:0]   and_rin,
    output logic           AndEnable,
    input  logic           AndDone,
    input  logic [D-1:0]   and_out
);

    localparam int GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, RESP, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] g_q, g_d;
    logic [GW-1:0] win;
    logic          found;
    int            best, off;
    logic [15:0]   lfsr_q, lfsr_d, lfsr_next;
    logic [D-1:0]  ina_q, ina_d, inb_q, inb_d;
    logic [D-1:0]  rin_q, rin_d, res_q, res_d;
    logic [D-1:0]  ina_sel, inb_sel;

`ifdef AND_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
`else
    // TIMEOUT only matters when the watchdog is compiled in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT > 0);
`endif

    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Winner is the requester with the smallest distance from rr_ptr, wrapping modulo N.
    always_comb begin
        best  = N;
        off   = 0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            off = (i + N - int'(rr_ptr_q)) % N;
            if (req[i] && off < best) begin
                best  = off;
                win   = GW'(i);
                found = 1'b1;
            end
        end
        ina_sel = '0;
        inb_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (win == GW'(i)) begin
                ina_sel = ina_bus[i*D +: D];
                inb_sel = inb_bus[i*D +: D];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        g_d      = g_q;
        lfsr_d   = lfsr_q;
        ina_d    = ina_q;
        inb_d    = inb_q;
        rin_d    = rin_q;
        res_d    = res_q;
`ifdef AND_TIMEOUT_EN
        cnt_d    = cnt_q;
        to_d     = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    g_d     = win;
                    ina_d   = ina_sel;
                    inb_d   = inb_sel;
                    rin_d   = lfsr_q[D-1:0];
                    lfsr_d  = lfsr_next;
                    state_d = RUN;
`ifdef AND_TIMEOUT_EN
                    cnt_d   = '0;
                    to_d    = 1'b0;
`endif
                end
            end
            RUN: begin
                if (AndDone) begin
                    res_d   = and_out;
                    state_d = RESP;
                end
`ifdef AND_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    to_d    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            RESP: begin
                rr_ptr_d = (g_q == GW'(N - 1)) ? '0 : g_q + GW'(1);
`ifdef AND_TIMEOUT_EN
                state_d  = (AndDone || to_q) ? DRAIN : IDLE;
`else
                state_d  = AndDone ? DRAIN : IDLE;
`endif
            end
            DRAIN: begin
                // A gadget still holding done must release it before the next operation starts.
                if (!AndDone) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            g_q      <= '0;
            lfsr_q   <= SEED;
            ina_q    <= '0;
            inb_q    <= '0;
            rin_q    <= '0;
            res_q    <= '0;
`ifdef AND_TIMEOUT_EN
            cnt_q    <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            g_q      <= g_d;
            lfsr_q   <= lfsr_d;
            ina_q    <= ina_d;
            inb_q    <= inb_d;
            rin_q    <= rin_d;
            res_q    <= res_d;
`ifdef AND_TIMEOUT_EN
            cnt_q    <= cnt_d;
            to_q     <= to_d;
`endif
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == RESP) ack[g_q] = 1'b1;
    end

    assign res       = res_q;
    assign busy      = (state_q != IDLE);
    assign AndEnable = (state_q == RUN);
    assign and_ina   = ina_q;
    assign and_inb   = inb_q;
    assign and_rin   = rin_q;

`ifdef AND_TIMEOUT_EN
    assign timeout = (state_q == RESP) && to_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_and_gadget_arbiter.sv
// Bench for and_gadget_arbiter: gadget model plus a scoreboard of expected acks.
module tb_and_gadget_arbiter;

    localparam int          N    = 2;
    localparam int          D    = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*D-1:0] ina_bus = '0;
    logic [N*D-1:0] inb_bus = '0;
    logic [N-1:0]   ack;
    logic [D-1:0]   res, and_ina, and_inb, and_rin, and_out;
    logic           timeout, busy, AndEnable;
    logic           AndDone = 1'b0;

    typedef struct packed {
        logic [N-1:0] ack;
        logic [D-1:0] res;
        logic         tmo;
        logic [D-1:0] rin;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_lfsr = SEED;
    int          vectors = 0;
    int          miscompares = 0;
    int          g_cnt = 0;
    int          g_hold = 0;
    int          extra_hold = 0;
    bit          never_done = 1'b0;

    always #5 clk = ~clk;

    and_gadget_arbiter #(.N(N), .D(D), .SEED(SEED), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .ina_bus(ina_bus), .inb_bus(inb_bus),
        .ack(ack), .res(res), .timeout(timeout), .busy(busy),
        .and_ina(and_ina), .and_inb(and_inb), .and_rin(and_rin),
        .AndEnable(AndEnable), .AndDone(AndDone), .and_out(and_out)
    );

    // Gadget model: done rises 3 cycles after enable, held until enable drops (+extra_hold).
    assign and_out = (and_ina & and_inb) ^ and_rin;
    always @(posedge clk) begin
        if (AndEnable) begin
            if (g_cnt < 3) g_cnt <= g_cnt + 1;
            AndDone <= !never_done && (g_cnt >= 2);
            g_hold  <= extra_hold;
        end else if (AndDone && g_hold > 0) begin
            g_hold <= g_hold - 1;
        end else begin
            AndDone <= 1'b0;
            g_cnt   <= 0;
        end
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic void push_exp(input logic [N-1:0] a1h, input logic [D-1:0] a,
                                     input logic [D-1:0] b, input logic tmo);
        exp_t e;
        e.ack = a1h;
        e.rin = m_lfsr[D-1:0];
        e.res = tmo ? '0 : ((a & b) ^ m_lfsr[D-1:0]);
        e.tmo = tmo;
        exp_q.push_back(e);
        m_lfsr = lfsr_step(m_lfsr);
    endfunction

    task automatic next_ack(input int bound, output exp_t obs, output exp_t want, output int en);
        en   = 0;
        want = '0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ack != '0) break;
            if (AndEnable) en++;
        end
        obs = {ack, res, timeout, and_rin};
        if (exp_q.size() > 0) want = exp_q.pop_front();
    endtask

    task automatic wait_enable(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (AndEnable) break;
        end
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; ina_bus = '0; inb_bus = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({ack, res, timeout, busy, AndEnable} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 0", {ack, res, timeout, busy, AndEnable});
        end
        vectors++;
        if ({and_ina, and_inb, and_rin} !== '0) begin
            miscompares++;
            $display("FAIL reset_operands: got %b want 0", {and_ina, and_inb, and_rin});
        end
        rst = 1'b0;
        m_lfsr = SEED;
        exp_q.delete();
    endtask

    task automatic test_basic();
        exp_t obs, want;
        int   en;
        ina_bus = {3'b000, 3'b111};
        inb_bus = {3'b000, 3'b110};
        req = 2'b01;
        push_exp(2'b01, 3'b111, 3'b110, 1'b0);
        @(negedge clk);
        vectors++;
        if ({AndEnable, busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL grant_latency: got en/busy=%b want 11", {AndEnable, busy});
        end
        req = '0;
        next_ack(20, obs, want, en);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL basic_ack: got %b want %b", obs, want);
        end
        vectors++;
        if (en + 1 != 4) begin
            miscompares++;
            $display("FAIL enable_len: got %0d want 4", en + 1);
        end
        wait_idle(10);
        vectors++;
        if ({busy, AndEnable} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_after_drain: got busy/en=%b want 00", {busy, AndEnable});
        end
    endtask

    task automatic test_alternate();
        exp_t obs, want;
        int   en;
        test_reset();
        ina_bus = {3'b011, 3'b000};
        inb_bus = {3'b011, 3'b110};
        req = 2'b11;
        for (int k = 0; k < 2; k++) begin
            push_exp(2'b01, 3'b000, 3'b110, 1'b0);
            push_exp(2'b10, 3'b011, 3'b011, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            next_ack(30, obs, want, en);
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL alt_ack%0d: got %b want %b", k, obs, want);
            end
            if (k == 3) req = '0;
            @(negedge clk);
            vectors++;
            if (ack !== '0) begin
                miscompares++;
                $display("FAIL ack_one_cycle%0d: got %b want 00", k, ack);
            end
        end
        wait_idle(10);
    endtask

    task automatic test_reset_in_run();
        exp_t obs, want;
        int   en;
        ina_bus = {3'b101, 3'b010};
        inb_bus = {3'b111, 3'b011};
        req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({AndEnable, ack, busy, timeout, and_rin} !== '0) begin
            miscompares++;
            $display("FAIL rst_abort: got %b want 0", {AndEnable, ack, busy, timeout, and_rin});
        end
        rst = 1'b0;
        m_lfsr = SEED;
        exp_q.delete();
        push_exp(2'b01, 3'b010, 3'b011, 1'b0);
        @(negedge clk);
        req = '0;
        next_ack(20, obs, want, en);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL rst_regrant: got %b want %b", obs, want);
        end
        wait_idle(10);
    endtask

    task automatic test_drain();
        exp_t obs, want;
        int   en, gap;
        ina_bus = {3'b110, 3'b101};
        inb_bus = {3'b011, 3'b111};
        extra_hold = 5;
        req = 2'b01;
        push_exp(2'b01, 3'b101, 3'b111, 1'b0);
        @(negedge clk);
        req = 2'b10;
        push_exp(2'b10, 3'b110, 3'b011, 1'b0);
        next_ack(20, obs, want, en);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL drain_first: got %b want %b", obs, want);
        end
        extra_hold = 0;
        gap = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            gap++;
            if (AndEnable) break;
        end
        vectors++;
        if (gap != 8) begin
            miscompares++;
            $display("FAIL drain_gap: got %0d cycles want 8", gap);
        end
        req = '0;
        next_ack(20, obs, want, en);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL drain_second: got %b want %b", obs, want);
        end
        wait_idle(10);
    endtask

`ifdef AND_TIMEOUT_EN
    task automatic test_timeout();
        exp_t obs, want;
        int   en;
        never_done = 1'b1;
        ina_bus = {3'b111, 3'b111};
        inb_bus = {3'b101, 3'b110};
        req = 2'b01;
        push_exp(2'b01, 3'b111, 3'b110, 1'b1);
        @(negedge clk);
        req = 2'b10;
        push_exp(2'b10, 3'b111, 3'b101, 1'b0);
        next_ack(40, obs, want, en);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL timeout_ack: got %b want %b", obs, want);
        end
        vectors++;
        if (en + 1 != 16) begin
            miscompares++;
            $display("FAIL timeout_len: got %0d want 16", en + 1);
        end
        never_done = 1'b0;
        wait_enable(20);
        req = '0;
        next_ack(20, obs, want, en);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL after_timeout: got %b want %b", obs, want);
        end
        wait_idle(10);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_alternate();
        test_reset_in_run();
        test_drain();
`ifdef AND_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang want finish");
        $fatal(1);
    end

endmodule
